// File: rtl/nios_ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port RAM with 1-cycle read latency.
// Grant is combinational; a registered tag steers each read return to its requester.
module nios_ram_arbiter #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [ADDR_W-1:0]   s0_address,
   input  logic                s0_read,
   input  logic                s0_write,
   input  logic [DATA_W/8-1:0] s0_byteenable,
   input  logic [DATA_W-1:0]   s0_writedata,
   output logic                s0_waitrequest,
   output logic [DATA_W-1:0]   s0_readdata,
   output logic                s0_readdatavalid,
   input  logic [ADDR_W-1:0]   s1_address,
   input  logic                s1_read,
   input  logic                s1_write,
   input  logic [DATA_W/8-1:0] s1_byteenable,
   input  logic [DATA_W-1:0]   s1_writedata,
   output logic                s1_waitrequest,
   output logic [DATA_W-1:0]   s1_readdata,
   output logic                s1_readdatavalid,
   output logic [ADDR_W-1:0]   ram_address,
   output logic [DATA_W/8-1:0] ram_byteenable,
   output logic [DATA_W-1:0]   ram_writedata,
   output logic                ram_chipselect,
   output logic                ram_write,
   output logic                ram_clken,
   input  logic [DATA_W-1:0]   ram_readdata
);

   logic r_last_grant;
   logic r_tag_valid;
   logic r_tag_idx;

   logic w_req0;
   logic w_req1;
   logic w_gnt_valid;
   logic w_gnt_idx;
   logic w_gnt_rd;
   logic w_gnt_wr;

   always_comb begin
      w_req0      = s0_read | s0_write;
      w_req1      = s1_read | s1_write;
      // Reset gates the grant so nothing reaches the RAM while reset_n is low.
      w_gnt_valid = reset_n & (w_req0 | w_req1);
      w_gnt_idx   = (w_req0 & w_req1) ? ~r_last_grant : w_req1;
      w_gnt_rd    = w_gnt_idx ? s1_read  : s0_read;
      w_gnt_wr    = w_gnt_idx ? s1_write : s0_write;
   end

   assign s0_waitrequest = ~(w_gnt_valid & ~w_gnt_idx);
   assign s1_waitrequest = ~(w_gnt_valid &  w_gnt_idx);

   assign ram_address    = w_gnt_idx ? s1_address    : s0_address;
   assign ram_byteenable = w_gnt_idx ? s1_byteenable : s0_byteenable;
   assign ram_writedata  = w_gnt_idx ? s1_writedata  : s0_writedata;
   assign ram_chipselect = w_gnt_valid;
   assign ram_write      = w_gnt_valid & w_gnt_wr;
   assign ram_clken      = reset_n;

   assign s0_readdata      = ram_readdata;
   assign s1_readdata      = ram_readdata;
   assign s0_readdatavalid = r_tag_valid & ~r_tag_idx;
   assign s1_readdatavalid = r_tag_valid &  r_tag_idx;

   // Write wins when read and write are both asserted, so such a command never tags a return.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_last_grant <= 1'b1;
         r_tag_valid  <= 1'b0;
         r_tag_idx    <= 1'b0;
      end else if (w_gnt_valid) begin
         r_last_grant <= w_gnt_idx;
         r_tag_valid  <= w_gnt_rd & ~w_gnt_wr;
         r_tag_idx    <= w_gnt_idx;
      end else begin
         r_tag_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_nios_ram_arbiter.sv
// Self-checking bench: vector table plus hand sequences, with a read-return scoreboard
// fed from a reference copy of the RAM contents.
module tb_nios_ram_arbiter;

   localparam int AW = 12;
   localparam int DW = 32;
   localparam int BW = DW / 8;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [AW-1:0] s0_address, s1_address;
   logic          s0_read, s0_write, s1_read, s1_write;
   logic [BW-1:0] s0_byteenable, s1_byteenable;
   logic [DW-1:0] s0_writedata, s1_writedata;
   logic          s0_waitrequest, s1_waitrequest;
   logic [DW-1:0] s0_readdata, s1_readdata;
   logic          s0_readdatavalid, s1_readdatavalid;
   logic [AW-1:0] ram_address;
   logic [BW-1:0] ram_byteenable;
   logic [DW-1:0] ram_writedata;
   logic          ram_chipselect, ram_write, ram_clken;
   logic [DW-1:0] ram_readdata;

   always #5 clk = ~clk;

   nios_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset_n(reset_n),
      .s0_address(s0_address), .s0_read(s0_read), .s0_write(s0_write),
      .s0_byteenable(s0_byteenable), .s0_writedata(s0_writedata),
      .s0_waitrequest(s0_waitrequest), .s0_readdata(s0_readdata),
      .s0_readdatavalid(s0_readdatavalid),
      .s1_address(s1_address), .s1_read(s1_read), .s1_write(s1_write),
      .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
      .s1_waitrequest(s1_waitrequest), .s1_readdata(s1_readdata),
      .s1_readdatavalid(s1_readdatavalid),
      .ram_address(ram_address), .ram_byteenable(ram_byteenable),
      .ram_writedata(ram_writedata), .ram_chipselect(ram_chipselect),
      .ram_write(ram_write), .ram_clken(ram_clken), .ram_readdata(ram_readdata)
   );

   // Behavioural single-port RAM driven only by the DUT's RAM-side outputs.
   logic [DW-1:0] ram_mem [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (ram_clken && ram_chipselect) begin
         if (ram_write) begin
            for (int b = 0; b < BW; b++)
               if (ram_byteenable[b]) ram_mem[ram_address][b*8 +: 8] <= ram_writedata[b*8 +: 8];
         end else begin
            ram_readdata <= ram_mem[ram_address];
         end
      end
   end

   typedef struct {
      logic          r0, w0;
      logic [AW-1:0] a0;
      logic [DW-1:0] d0;
      logic [BW-1:0] be0;
      logic          r1, w1;
      logic [AW-1:0] a1;
      logic [DW-1:0] d1;
      logic [BW-1:0] be1;
      int            gnt;   // expected grant: 0, 1, or 2 for none
   } vec_t;

   typedef struct {
      int            due;
      int            port;
      logic [DW-1:0] data;
   } ret_t;

   logic [DW-1:0] ref_mem [0:(1<<AW)-1];
   ret_t          sb[$];
   vec_t          tbl[$];
   int            errors = 0;
   int            checks = 0;
   int            cyc = 0;
   int            pulses0 = 0;
   int            pulses1 = 0;

   always @(posedge clk) begin
      if (s0_readdatavalid) pulses0 <= pulses0 + 1;
      if (s1_readdatavalid) pulses1 <= pulses1 + 1;
   end

   function automatic vec_t mk(logic r0, logic w0, logic [AW-1:0] a0, logic [DW-1:0] d0,
                               logic [BW-1:0] be0, logic r1, logic w1, logic [AW-1:0] a1,
                               logic [DW-1:0] d1, logic [BW-1:0] be1, int gnt);
      vec_t v;
      v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.be0 = be0;
      v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.be1 = be1;
      v.gnt = gnt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      s0_read = v.r0; s0_write = v.w0; s0_address = v.a0; s0_writedata = v.d0; s0_byteenable = v.be0;
      s1_read = v.r1; s1_write = v.w1; s1_address = v.a1; s1_writedata = v.d1; s1_byteenable = v.be1;
   endtask

   // One cycle, entered and left at posedge+1.
   task automatic step(input vec_t v);
      ret_t          e;
      logic          ev0, ev1, gr, gw;
      logic [DW-1:0] ed, gd;
      logic [AW-1:0] ga;
      logic [BW-1:0] gbe;
      drive(v);
      #4;
      ev0 = 1'b0; ev1 = 1'b0; ed = '0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
         e = sb.pop_front();
         if (e.port == 0) ev0 = 1'b1; else ev1 = 1'b1;
         ed = e.data;
      end
      chk("s0_readdatavalid", s0_readdatavalid, ev0);
      chk("s1_readdatavalid", s1_readdatavalid, ev1);
      if (ev0) chk("s0_readdata", s0_readdata, ed);
      if (ev1) chk("s1_readdata", s1_readdata, ed);
      chk("s0_waitrequest", s0_waitrequest, v.gnt != 0);
      chk("s1_waitrequest", s1_waitrequest, v.gnt != 1);
      chk("ram_chipselect", ram_chipselect, v.gnt != 2);
      chk("ram_clken", ram_clken, 1'b1);
      if (v.gnt != 2) begin
         gr  = (v.gnt == 0) ? v.r0  : v.r1;
         gw  = (v.gnt == 0) ? v.w0  : v.w1;
         ga  = (v.gnt == 0) ? v.a0  : v.a1;
         gd  = (v.gnt == 0) ? v.d0  : v.d1;
         gbe = (v.gnt == 0) ? v.be0 : v.be1;
         chk("ram_write", ram_write, gw);
         chk("ram_address", ram_address, ga);
         if (gw) begin
            for (int b = 0; b < BW; b++)
               if (gbe[b]) ref_mem[ga][b*8 +: 8] = gd[b*8 +: 8];
         end else if (gr) begin
            e.due = cyc + 1; e.port = v.gnt; e.data = ref_mem[ga];
            sb.push_back(e);
         end
      end else begin
         chk("ram_write", ram_write, 1'b0);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk_reset();
      chk("rst s0_waitrequest", s0_waitrequest, 1'b1);
      chk("rst s1_waitrequest", s1_waitrequest, 1'b1);
      chk("rst ram_chipselect", ram_chipselect, 1'b0);
      chk("rst ram_write", ram_write, 1'b0);
      chk("rst ram_clken", ram_clken, 1'b0);
      chk("rst s0_readdatavalid", s0_readdatavalid, 1'b0);
      chk("rst s1_readdatavalid", s1_readdatavalid, 1'b0);
   endtask

   vec_t idle, both_rd;

   initial begin
      for (int i = 0; i < (1<<AW); i++) begin
         ram_mem[i] = '0;
         ref_mem[i] = '0;
      end
      ram_readdata = '0;
      idle    = mk(0,0,12'h000,32'h0,4'h0, 0,0,12'h000,32'h0,4'h0, 2);
      both_rd = mk(1,0,12'h010,32'h0,4'hF, 1,0,12'h0FF,32'h0,4'hF, 0);

      // Requests (including a write) held high through reset must be ignored.
      reset_n = 1'b0;
      drive(mk(1,1,12'h005,32'h77,4'hF, 1,0,12'h006,32'h0,4'hF, 2));
      @(posedge clk); #1;
      chk_reset();
      @(posedge clk); #1;
      chk_reset();
      reset_n = 1'b1;

      // First contest after reset: requester 0 wins, then 1.
      step(mk(1,0,12'h001,32'h0,4'hF, 1,0,12'h002,32'h0,4'hF, 0));
      step(mk(0,0,12'h001,32'h0,4'hF, 1,0,12'h002,32'h0,4'hF, 1));

      tbl.push_back(mk(0,1,12'h010,32'hDEADBEEF,4'hF, 0,0,12'h000,32'h0,4'h0, 0));
      tbl.push_back(mk(1,0,12'h010,32'h0,4'hF,        0,0,12'h000,32'h0,4'h0, 0));
      tbl.push_back(idle);
      tbl.push_back(mk(0,0,12'h000,32'h0,4'h0, 0,1,12'h0FF,32'hAABBCCDD,4'hF, 1));
      tbl.push_back(mk(0,0,12'h000,32'h0,4'h0, 0,1,12'h0FF,32'h12345678,4'h3, 1));
      tbl.push_back(mk(0,0,12'h000,32'h0,4'h0, 1,0,12'h0FF,32'h0,4'hF,        1));
      tbl.push_back(idle);
      tbl.push_back(mk(1,1,12'h020,32'h0BADF00D,4'hF, 0,0,12'h000,32'h0,4'h0, 0));
      tbl.push_back(mk(1,0,12'h020,32'h0,4'hF,        0,0,12'h000,32'h0,4'h0, 0));
      tbl.push_back(idle);
      tbl.push_back(mk(1,0,12'h010,32'h0,4'hF, 1,0,12'h0FF,32'h0,4'hF, 1));
      tbl.push_back(mk(1,0,12'h010,32'h0,4'hF, 1,0,12'h0FF,32'h0,4'hF, 0));
      tbl.push_back(idle);
      tbl.push_back(mk(0,1,12'h030,32'h11111111,4'hF, 0,1,12'h031,32'h22222222,4'hF, 1));
      tbl.push_back(mk(0,1,12'h030,32'h11111111,4'hF, 0,0,12'h000,32'h0,4'h0,        0));
      tbl.push_back(mk(1,0,12'h030,32'h0,4'hF,        1,0,12'h031,32'h0,4'hF,        1));
      tbl.push_back(mk(1,0,12'h030,32'h0,4'hF,        0,0,12'h000,32'h0,4'h0,        0));
      tbl.push_back(mk(0,0,12'h000,32'h0,4'h0, 0,1,12'h040,32'h5,4'hF, 1));
      foreach (tbl[i]) step(tbl[i]);

      // Continuous contention for 8 cycles: strict alternation starting with 0.
      pulses0 = 0;
      pulses1 = 0;
      for (int i = 0; i < 8; i++) begin
         both_rd.gnt = i % 2;
         step(both_rd);
      end
      step(idle);
      chk("s0 pulses in 8-cycle contest", pulses0, 4);
      chk("s1 pulses in 8-cycle contest", pulses1, 4);

      // Reset arriving while a read return is pending must cancel it.
      step(mk(0,0,12'h000,32'h0,4'h0, 1,0,12'h0FF,32'h0,4'hF, 1));
      reset_n = 1'b0;
      drive(idle);
      #4;
      chk_reset();
      sb.delete();
      @(posedge clk); #1;
      drive(both_rd);
      #4;
      chk_reset();
      @(posedge clk); #1;
      reset_n = 1'b1;
      step(idle);
      both_rd.gnt = 0;
      step(both_rd);
      both_rd.gnt = 1;
      step(both_rd);
      step(idle);
      chk("scoreboard drained", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout cycle=%0d got=running expected=finished", cyc);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/nios_ram_arbiter.md
NIOS_RAM_ARBITER -- requirements
Module: nios_ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, word address width of the shared RAM.
REQ-002 SHALL have parameter DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have, for N = 0 and 1, ports sN_address  input  ADDR_W  requester N word address.
REQ-006 SHALL have ports sN_read and sN_write  input  1 each  requester N read or write request.
REQ-007 SHALL have ports sN_byteenable  input  DATA_W/8  and  sN_writedata  input  DATA_W  requester N write lanes and data.
REQ-008 SHALL have ports sN_waitrequest  output  1  high while requester N's command is not accepted.
REQ-009 SHALL have ports sN_readdata  output  DATA_W  and  sN_readdatavalid  output  1  requester N read return.
REQ-010 SHALL have ports ram_address  output  ADDR_W,  ram_byteenable  output  DATA_W/8,  ram_writedata  output  DATA_W.
REQ-011 SHALL have ports ram_chipselect, ram_write, ram_clken  output  1 each  RAM command strobes and clock enable.
REQ-012 SHALL have port ram_readdata  input  DATA_W  RAM output, valid exactly one cycle after a read command.

Function
REQ-013 SHALL share one single-port RAM (1-cycle read latency) between requesters 0 and 1; one command per cycle maximum.
REQ-014 SHALL treat requester N as requesting when sN_read or sN_write is high.
REQ-015 SHALL grant combinationally within the same cycle: sole requester wins; if both request, the requester not granted most recently wins (round-robin).
REQ-016 SHALL hold a 1-bit last_grant register, updated on every accepted command to the granted index.
REQ-017 SHALL drive sN_waitrequest low for the granted requester and high for a requesting, non-granted requester; sN_waitrequest SHALL be high when requester N is idle.
REQ-018 SHALL drive ram_address/byteenable/writedata from the granted requester, ram_chipselect high and ram_write = granted sN_write in the grant cycle; ram_chipselect and ram_write low when no grant.
REQ-019 SHALL, when sN_read and sN_write are both high, execute a write only (write precedence); no readdatavalid follows.
REQ-020 SHALL record accepted reads in a registered tag (valid bit plus requester index); next cycle assert sN_readdatavalid for exactly one cycle to the tagged requester only.
REQ-021 SHALL route sN_readdata = ram_readdata to both ports continuously; only sN_readdatavalid qualifies it.
REQ-022 SHALL sustain back-to-back accepted commands every cycle, including read-after-write to the same address (RAM read-during-write value undefined; bench SHALL not check it).
REQ-023 SHALL give a continuously requesting port at least one grant in every two consecutive cycles when both request (no starvation).
REQ-024 SHALL drive ram_clken high whenever reset_n is high.

Reset
REQ-025 SHALL, while reset_n is low, force last_grant = 1 (so requester 0 wins the first contest), read tag invalid, ram_clken = 0, both sN_readdatavalid = 0.
REQ-026 SHALL, on reset asserted mid-read (tag valid), drop the pending readdatavalid; no return after reset release.
REQ-027 SHALL drive ram_chipselect = 0, ram_write = 0 and both sN_waitrequest = 1 during reset regardless of requests.

Verification
REQ-028 SHALL pass: reset release, s0 write addr 0x010 data 0xDEADBEEF be 0xF, then s0 read 0x010 -> s0_waitrequest low both cycles, s0_readdatavalid one cycle after read with 0xDEADBEEF, s1_readdatavalid stays 0.
REQ-029 SHALL pass: first cycle after reset both read (s0 0x001, s1 0x002) -> s0 granted cycle 0, s1 granted cycle 1, valids return in cycles 1 and 2 to the matching port.
REQ-030 SHALL pass: both hold continuous reads for 8 cycles -> grants alternate 0,1,0,1,...; each port gets 4 readdatavalid pulses.
REQ-031 SHALL pass: s1 write 0x0FF data 0x12345678 be 0x3, then read -> low halfword 0x5678 updated, upper halfword unchanged.
REQ-032 SHALL pass: s0_read and s0_write high together -> RAM write occurs, no s0_readdatavalid next cycle.
REQ-033 SHALL pass: reset_n low one cycle after accepted s1 read -> s1_readdatavalid never pulses; after release requester 0 wins first contest.
